receiver: RTL and testbench

Serial-to-parallel UART receiver; counterpart to the transmitter on the same 8N1 link. Runs on an oversampling tick clock from the baud rate generator, synchronizes the FTDI RX line, centre-samples each bit, and hands one byte per frame to the receive buffer with a one-cycle `done` pulse. Bad stop bits are flagged on `frameError`; no byte is delivered for those frames.

---
 rtl/receiver_if.sv | 22 ++
 rtl/receiver.sv | 154 +++++++++++++++
 tb/tb_receiver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/receiver_if.sv
// Serial receive link: the FTDI RX line in, the received byte and its status pulses out.
// The receiver takes the master side; the receive buffer (or a testbench) takes the slave side.
interface receiver_if;
  logic       receiveInput;
  logic [7:0] byteReceived;
  logic       done;
  logic       frameError;

  modport master (
    input  receiveInput,
    output byteReceived,
    output done,
    output frameError
  );

  modport slave (
    output receiveInput,
    input  byteReceived,
    input  done,
    input  frameError
  );
endinterface

// File: rtl/receiver.sv
// 8N1 UART receiver on an OVERSAMPLE x baud tick clock, centre-sampling each bit.
// Define UART_RX_MAJORITY_EN to take every sample decision as a 3-sample majority vote.
module receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  receiver_if.master bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    STOP,
    BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] sampleCount_q, sampleCount_d;
  logic [2:0]    bitIndex_q, bitIndex_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          frameError_q, frameError_d;
  logic          rxSync;
  logic          sampleBit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.receiveInput};
    end
  end

  assign rxSync = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // The two previous rxSync values plus the current one form the 3-entry voting window.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxSync};
    end
  end

  assign sampleBit = (rxSync & hist_q[0]) | (rxSync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sampleBit = rxSync;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sampleCount_q <= '0;
      bitIndex_q    <= '0;
      shift_q       <= '0;
      byte_q        <= '0;
      done_q        <= 1'b0;
      frameError_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sampleCount_q <= sampleCount_d;
      bitIndex_q    <= bitIndex_d;
      shift_q       <= shift_d;
      byte_q        <= byte_d;
      done_q        <= done_d;
      frameError_q  <= frameError_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sampleCount_d = sampleCount_q;
    bitIndex_d    = bitIndex_q;
    shift_d       = shift_q;
    byte_d        = byte_q;
    done_d        = 1'b0;
    frameError_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sampleCount_d = '0;
        if (!rxSync) begin
          state_d = START;
        end
      end

      // Half a bit in, the start bit must still be low or it was only a glitch.
      START: begin
        sampleCount_d = sampleCount_q + CW'(1);
        if (sampleCount_q == HALF_LAST) begin
          sampleCount_d = '0;
          bitIndex_d    = '0;
          state_d       = sampleBit ? IDLE : RECEIVE;
        end
      end

      RECEIVE: begin
        sampleCount_d = sampleCount_q + CW'(1);
        if (sampleCount_q == BIT_LAST) begin
          sampleCount_d        = '0;
          shift_d[bitIndex_q]  = sampleBit;
          bitIndex_d           = bitIndex_q + 3'd1;
          if (bitIndex_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        sampleCount_d = sampleCount_q + CW'(1);
        if (sampleCount_q == BIT_LAST) begin
          sampleCount_d = '0;
          if (sampleBit) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frameError_d = 1'b1;
            state_d      = BREAK;
          end
        end
      end

      // A line held low after a bad stop bit must not be mistaken for a new start.
      BREAK: begin
        sampleCount_d = '0;
        if (rxSync) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        sampleCount_d = '0;
      end
    endcase
  end

  assign bus.byteReceived = byte_q;
  assign bus.done         = done_q;
  assign bus.frameError   = frameError_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table-driven frames, corner-case sequences and random frames
// checked cycle by cycle against expected pulse times derived from the frame timing rules.
module tb_receiver;

  localparam int OS = 16;
  localparam int FRAME = 10 * OS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  receiver_if bus();

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cycle;
    bit         isErr;
    logic [7:0] data;
  } evt_t;

  typedef struct {
    logic [7:0] data;
    bit         stopBit;
    int         gapAfter;
    bit         expErr;
    logic [7:0] expByte;
  } vec_t;

  evt_t       expQ[$];
  int         cyc = 0;
  int         assertCount = 0;
  int         failCount = 0;
  logic [7:0] modelByte = 8'h00;
  bit         monEn = 1'b0;
  evt_t       cur;
  bit         expD;
  bit         expE;
  vec_t       vecs[8];

  always @(posedge clk) cyc = cyc + 1;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit lineBit(logic [7:0] d, bit stopBit, int c);
    int idx;
    idx = c / OS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return stopBit;
  endfunction

  // Expected pulse lands in the cycle after edge T0 + 2 + OS/2 + 9*OS (stop-bit sample).
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input int glitch,
                               input int nCycles, input bit expErr, input logic [7:0] expByte);
    int   t0;
    evt_t e;
    bit   v;
    t0 = cyc + 1;
    if (nCycles == FRAME) begin
      e.cycle = t0 + 2 + OS / 2 + 9 * OS;
      e.isErr = expErr;
      e.data  = expByte;
      expQ.push_back(e);
    end
    for (int c = 0; c < nCycles; c++) begin
      v = lineBit(data, stopBit, c);
      if (c == glitch) v = ~v;
      bus.receiveInput = v;
      @(negedge clk);
    end
  endtask

  task automatic idleFor(input int n);
    bus.receiveInput = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic lowFor(input int n);
    bus.receiveInput = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      expD = 1'b0;
      expE = 1'b0;
      while (expQ.size() > 0 && expQ[0].cycle < cyc) void'(expQ.pop_front());
      if (expQ.size() > 0 && expQ[0].cycle == cyc) begin
        cur  = expQ.pop_front();
        expE = cur.isErr;
        expD = !cur.isErr;
        if (expD) modelByte = cur.data;
      end
      checkOutput("done", {31'd0, bus.done}, {31'd0, expD});
      checkOutput("frameError", {31'd0, bus.frameError}, {31'd0, expE});
      checkOutput("byteReceived", {24'd0, bus.byteReceived}, {24'd0, modelByte});
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] prevByte;
    logic [7:0] rData;
    bit         rBad;

    vecs[0] = '{8'h55, 1'b1, 20, 1'b0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 0,  1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 30, 1'b0, 8'h3C};
    vecs[3] = '{8'hFF, 1'b1, 0,  1'b0, 8'hFF};
    vecs[4] = '{8'h00, 1'b1, 5,  1'b0, 8'h00};
    vecs[5] = '{8'h81, 1'b0, 40, 1'b1, 8'h00};
    vecs[6] = '{8'h80, 1'b1, 3,  1'b0, 8'h80};
    vecs[7] = '{8'h01, 1'b0, 20, 1'b1, 8'h00};

    rst = 1'b1;
    bus.receiveInput = 1'b1;
    #2;
    checkOutput("resetByte", {24'd0, bus.byteReceived}, 32'h0);
    checkOutput("resetDone", {31'd0, bus.done}, 32'h0);
    checkOutput("resetFrameError", {31'd0, bus.frameError}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    monEn = 1'b1;
    idleFor(10);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopBit, -1, FRAME, vecs[i].expErr, vecs[i].expByte);
      idleFor(vecs[i].gapAfter);
    end

    // False start: a 5-cycle low pulse must leave everything untouched.
    prevByte = modelByte;
    lowFor(5);
    idleFor(40);
    checkOutput("falseStartByte", {24'd0, bus.byteReceived}, {24'd0, prevByte});

    // Bad stop bit, line held low, then a good frame.
    applyStimulus(8'h81, 1'b0, -1, FRAME, 1'b1, 8'h00);
    lowFor(40);
    idleFor(20);
    applyStimulus(8'h12, 1'b1, -1, FRAME, 1'b0, 8'h12);
    idleFor(10);

    // Asynchronous reset in the middle of data bit 4.
    applyStimulus(8'hC3, 1'b1, -1, 5 * OS + 8, 1'b0, 8'h00);
    #3;
    rst = 1'b1;
    modelByte = 8'h00;
    #1;
    checkOutput("midResetByte", {24'd0, bus.byteReceived}, 32'h0);
    checkOutput("midResetDone", {31'd0, bus.done}, 32'h0);
    checkOutput("midResetFrameError", {31'd0, bus.frameError}, 32'h0);
    bus.receiveInput = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idleFor(20);
    applyStimulus(8'h7E, 1'b1, -1, FRAME, 1'b0, 8'h7E);
    idleFor(10);

    // One-cycle inversion landing on the data-bit-2 sample edge (T0+58, captured at T0+56).
`ifdef UART_RX_MAJORITY_EN
    applyStimulus(8'h00, 1'b1, 56, FRAME, 1'b0, 8'h00);
`else
    applyStimulus(8'h00, 1'b1, 56, FRAME, 1'b0, 8'h04);
`endif
    idleFor(10);

    for (int i = 0; i < 15; i++) begin
      rData = 8'($urandom_range(0, 255));
      rBad  = ($urandom_range(0, 4) == 0);
      applyStimulus(rData, !rBad, -1, FRAME, rBad, rData);
      if (rBad) idleFor(20 + $urandom_range(0, 10));
      else      idleFor($urandom_range(0, 12));
    end

    idleFor(200);
    checkOutput("pendingEvents", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
